// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Micro-sequencer that walks a small program of ALU operations and drives the
//   register-bank/ALU datapath: per instruction it presents read/write
//   addresses and the ALU selector, pulses init, waits for alu_done, then
//   pulses RegWrite. It stops on a halt bit or after the last memory entry.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin execution at pc=0 (accepted only in IDLE)
//   prog_we/addr/data     program-memory write port (ignored while busy)
//                         data: [14]=halt [13:12]=selector [11:8]=Ra [7:4]=Rb [3:0]=W
//   alu_done              ALU result valid (sampled only while waiting)
//   addrRa/addrRb/addrW   register-bank addresses
//   selector              ALU operation
//   init, RegWrite        one-cycle ALU start / register write pulses
//   busy, done, pc        status: running, end-of-program pulse, current index
//   error                 sticky watchdog flag
//
// Build option
//   SEQ_TIMEOUT_EN        when defined, a watchdog aborts a WAIT lasting
//                         TIMEOUT_CYCLES cycles and sets error; otherwise
//                         WAIT is unbounded and error is tied low.
module alu_sequencer #(
  parameter int PROG_DEPTH     = 16,
  parameter int PC_W           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [14:0]     prog_data,
  input  logic            alu_done,
  output logic [3:0]      addrRa,
  output logic [3:0]      addrRb,
  output logic [3:0]      addrW,
  output logic [1:0]      selector,
  output logic            init,
  output logic            RegWrite,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc,
  output logic            error
);

  if (PROG_DEPTH != (1 << PC_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_sequencer: inconsistent PROG_DEPTH/PC_W or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [14:0]     mem [PROG_DEPTH];
  logic            mem_wr;
  logic [PC_W-1:0] pc_n;
  logic [3:0]      ra_n, rb_n, w_n;
  logic [1:0]      sel_n;
  logic [14:0]     fetch;
  logic            last;
  logic            timeout;

  assign mem_wr = prog_we && !busy;

  // Program memory: no reset, survives rst.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Memory cannot change while busy, so the current entry is stable here.
  assign last = mem[pc][14] || (pc == PC_W'(PROG_DEPTH - 1));

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (!alu_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == S_WAIT) && !alu_done &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ra_n    = addrRa;
    rb_n    = addrRb;
    w_n     = addrW;
    sel_n   = selector;
    fetch   = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
          pc_n    = '0;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          state_n = S_WRITE;
        end else if (timeout) begin
          state_n = S_DONE;
        end
      end
      S_WRITE: begin
        if (last) begin
          state_n = S_DONE;
        end else begin
          pc_n    = pc + 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered, so the instruction is fetched on the edge that
    // enters ISSUE. A write landing on that same edge is forwarded so that a
    // program loaded together with start executes its new entry.
    fetch = mem[pc_n];
    if (mem_wr && prog_addr == pc_n) begin
      fetch = prog_data;
    end
    if (state_n == S_ISSUE) begin
      sel_n = fetch[13:12];
      ra_n  = fetch[11:8];
      rb_n  = fetch[7:4];
      w_n   = fetch[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      addrRa   <= '0;
      addrRb   <= '0;
      addrW    <= '0;
      selector <= '0;
      init     <= 1'b0;
      RegWrite <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      addrRa   <= ra_n;
      addrRb   <= rb_n;
      addrW    <= w_n;
      selector <= sel_n;
      init     <= (state_n == S_ISSUE);
      RegWrite <= (state_n == S_WRITE);
      busy     <= (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_WRITE);
      done     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: reset values, a table of single
// instruction runs (including load-with-start and alu_done already high),
// multi-instruction programs checked against a program-level reference,
// start/write while busy, reset mid-program, and the optional watchdog.
module tb_alu_sequencer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, start, prog_we, alu_done;
  logic [3:0]  prog_addr;
  logic [14:0] prog_data;
  logic [3:0]  addrRa, addrRb, addrW;
  logic [1:0]  selector;
  logic        init, RegWrite, busy, done, error;
  logic [3:0]  pc;

  int checks = 0;
  int errors = 0;
  logic [14:0] model_mem [DEPTH];

  alu_sequencer #(.PROG_DEPTH(16), .PC_W(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .alu_done(alu_done),
    .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW), .selector(selector),
    .init(init), .RegWrite(RegWrite), .busy(busy), .done(done),
    .pc(pc), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [14:0] d);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d;
    step();
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Number of instructions the program executes: up to the first halt or the last entry.
  function automatic int prog_len();
    for (int i = 0; i < DEPTH; i++)
      if (model_mem[i][14] || i == DEPTH - 1) return i + 1;
    return DEPTH;
  endfunction

  // Runs the loaded program from IDLE. The ALU responder raises alu_done
  // 'dly' cycles after init (random 0..4 when dfix<0) and holds it until
  // RegWrite. inject_cyc>0 drives start plus a write to entry 0 in that cycle.
  task automatic run_prog(input string tag, input int dfix, input int inject_cyc);
    int n, cyc, inits, wrs, init_cyc, wr_cyc, d, cur, adone_at;
    bit fin;
    n = prog_len();
    inits = 0; wrs = 0; init_cyc = -100; wr_cyc = -100; d = 0; cur = 0;
    adone_at = -1; fin = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      if (prog_we) begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
      if (!done) chk($sformatf("%s_busy_c%0d", tag, cyc), busy, 1);
      if (RegWrite) begin
        alu_done = 1'b0;
        chk($sformatf("%s_rw_latency_%0d", tag, cur), cyc, init_cyc + ((d == 0) ? 1 : d) + 1);
        chk($sformatf("%s_rw_pc_%0d", tag, cur), pc, cur);
        chk($sformatf("%s_rw_fields_%0d", tag, cur), {selector, addrRa, addrRb, addrW},
            model_mem[cur][13:0]);
        wr_cyc = cyc;
        wrs++;
      end
      if (init) begin
        chk($sformatf("%s_init_extra", tag), inits < n, 1);
        chk($sformatf("%s_init_latency_%0d", tag, inits), cyc, (inits == 0) ? 1 : wr_cyc + 1);
        chk($sformatf("%s_init_pc_%0d", tag, inits), pc, inits);
        chk($sformatf("%s_init_fields_%0d", tag, inits), {selector, addrRa, addrRb, addrW},
            model_mem[inits[3:0]][13:0]);
        cur = inits;
        inits++;
        init_cyc = cyc;
        d = (dfix >= 0) ? dfix : int'($urandom_range(0, 4));
        adone_at = init_cyc + d;
      end
      if (done) begin
        chk($sformatf("%s_init_count", tag), inits, n);
        chk($sformatf("%s_rw_count", tag), wrs, n);
        chk($sformatf("%s_done_latency", tag), cyc, wr_cyc + 1);
        chk($sformatf("%s_done_busy", tag), busy, 0);
        chk($sformatf("%s_final_pc", tag), pc, n - 1);
        fin = 1;
      end
      if (cyc == adone_at) alu_done = 1'b1;
      if (cyc == inject_cyc) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = ~model_mem[0];
      end
      if (!fin) begin
        step();
        cyc++;
      end
    end
    if (!fin) chk($sformatf("%s_done_seen", tag), 0, 1);
    alu_done = 1'b0;
    step();
    chk($sformatf("%s_idle_after", tag), {init, RegWrite, done, busy}, 0);
  endtask

  typedef struct {
    logic [14:0] instr;
    int          dly;
    bit          same;
    logic [3:0]  ra, rb, w;
    logic [1:0]  sel;
    int          rw_at;
    int          done_at;
  } vec_t;

  initial begin
    vec_t vt[4];
    int init_at, rw_at, dn_at, n_init, n_rw;
    logic [13:0] f;
    logic bsy, bad;

    rst = 1'b1; start = 1'b0; prog_we = 1'b0; alu_done = 1'b0;
    prog_addr = '0; prog_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset values
    step(); step();
    chk("rst_addr", {addrRa, addrRb, addrW, selector}, 0);
    chk("rst_pulses", {init, RegWrite, done}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    step();

    // Single-instruction table: {instr, alu delay, load-with-start, Ra, Rb, W, sel, RegWrite cycle, done cycle}
    vt[0] = '{15'h4123, 2, 1'b0, 4'h1, 4'h2, 4'h3, 2'b00, 4, 5};
    vt[1] = '{15'h5A5F, 0, 1'b1, 4'hA, 4'h5, 4'hF, 2'b01, 3, 4};
    vt[2] = '{15'h60F7, 1, 1'b0, 4'h0, 4'hF, 4'h7, 2'b10, 3, 4};
    vt[3] = '{15'h7990, 5, 1'b1, 4'h9, 4'h9, 4'h0, 2'b11, 7, 8};
    for (int v = 0; v < 4; v++) begin
      if (!vt[v].same) load(0, vt[v].instr);
      prog_we = vt[v].same; prog_addr = 4'd0; prog_data = vt[v].instr;
      model_mem[0] = vt[v].instr;
      start = 1'b1;
      step();
      start = 1'b0; prog_we = 1'b0;
      init_at = -1; rw_at = -1; dn_at = -1; n_init = 0; n_rw = 0; f = '0; bsy = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        if (RegWrite) begin
          alu_done = 1'b0;
          if (rw_at < 0) rw_at = c;
          n_rw++;
        end
        if (init) begin
          if (init_at < 0) begin
            init_at = c;
            f = {selector, addrRa, addrRb, addrW};
          end
          n_init++;
        end
        if (done && dn_at < 0) begin
          dn_at = c;
          bsy = busy;
        end
        if (c == 1 + vt[v].dly) alu_done = 1'b1;
        step();
      end
      alu_done = 1'b0;
      chk($sformatf("tbl%0d_init_cycle", v), init_at, 1);
      chk($sformatf("tbl%0d_fields", v), f, {vt[v].sel, vt[v].ra, vt[v].rb, vt[v].w});
      chk($sformatf("tbl%0d_rw_cycle", v), rw_at, vt[v].rw_at);
      chk($sformatf("tbl%0d_done_cycle", v), dn_at, vt[v].done_at);
      chk($sformatf("tbl%0d_pulse_counts", v), {n_init[7:0], n_rw[7:0]}, 16'h0101);
      chk($sformatf("tbl%0d_done_busy", v), bsy, 0);
    end

    // Three instructions, halt on entry 2
    load(0, 15'h1312);
    load(1, 15'h2456);
    load(2, 15'h4789);
    run_prog("three", 2, -1);

    // start + write to entry 0 while busy: ignored, entry 0 unchanged afterwards
    run_prog("busy_inject", 1, 2);
    run_prog("after_inject", 1, -1);

    // Reset during WAIT of the second instruction
    start = 1'b1; step(); start = 1'b0;           // cycle 1: ISSUE of entry 0
    chk("rstmid_init0", init, 1);
    step();                                       // cycle 2: WAIT
    alu_done = 1'b1;
    step();                                       // cycle 3: WRITE
    alu_done = 1'b0;
    chk("rstmid_rw0", RegWrite, 1);
    step();                                       // cycle 4: ISSUE of entry 1
    chk("rstmid_init1", {init, pc}, {1'b1, 4'd1});
    step();                                       // cycle 5: WAIT
    rst = 1'b1;
    step();
    chk("rstmid_outputs", {addrRa, addrRb, addrW, selector, init, RegWrite, busy, done, pc}, 0);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      alu_done = (c == 0);
      step();
      if (init || RegWrite || done || busy) bad = 1'b1;
    end
    alu_done = 1'b0;
    chk("rstmid_stays_idle", bad, 0);
    run_prog("after_rst", 1, -1);

    // No halt bits: all 16 entries run, pc stops at 15
    for (int i = 0; i < DEPTH; i++) load(i, 15'($urandom) & 15'h3FFF);
    run_prog("nohalt", -1, -1);

    // Random programs with random halts and random ALU latency
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_data = 15'($urandom);
        prog_data[14] = ($urandom_range(0, 4) == 0);
        load(i, prog_data);
      end
      run_prog($sformatf("rand%0d", r), -1, -1);
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: alu_done never arrives
    load(0, 15'h0123);
    start = 1'b1; step(); start = 1'b0;
    rw_at = -1; dn_at = -1; bsy = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (RegWrite && rw_at < 0) rw_at = c;
      if (done && dn_at < 0) begin
        dn_at = c;
        bsy = error;
      end
      step();
    end
    chk("wdog_done_cycle", dn_at, 66);
    chk("wdog_error_at_done", bsy, 1);
    chk("wdog_no_regwrite", rw_at, -1);
    chk("wdog_error_sticky", error, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("wdog_error_cleared", error, 0);
`else
    chk("error_tied_low", error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
